brute_force_gen: RTL and testbench

- Parametrised candidate-password generator for the cracker datapath; successor to the per-character counter chain.
- Fully synchronous odometer of MAX_CHARS character positions over a configurable ASCII range.
- Position 0 uses a programmable offset and stride so several workers can partition the keyspace.
- Length grows automatically from 1 up to MAX_CHARS. Candidates go to the controller over a valid/ready handshake.

---
 rtl/brute_force_gen.sv | 187 ++++++++++++++++++
 tb/tb_brute_force_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/brute_force_gen.sv
// Candidate-password generator: odometer over [CHAR_MIN..CHAR_MAX] with length growth and a valid/ready output.
// Optional BRUTE_FORCE_CAND_COUNT_EN adds a saturating 48-bit accepted-candidate counter (cand_count).
module brute_force_gen #(
   parameter int unsigned  MAX_CHARS = 16,
   parameter logic [7:0]   CHAR_MIN  = 8'h61,
   parameter logic [7:0]   CHAR_MAX  = 8'h7A,
   parameter int unsigned  STRIDE_W  = 3,
   localparam int unsigned NUM_W     = $clog2(MAX_CHARS + 1),
   localparam int unsigned PW_W      = 8 * MAX_CHARS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [7:0]          start_offset,
   input  logic [STRIDE_W-1:0] stride,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [PW_W-1:0]     password,
   output logic [NUM_W-1:0]    num_chars,
   output logic                busy,
   output logic                done,
`ifdef BRUTE_FORCE_CAND_COUNT_EN
   output logic                cfg_err,
   output logic [47:0]         cand_count
`else
   output logic                cfg_err
`endif
);

   localparam int unsigned RANGE = int'(CHAR_MAX) - int'(CHAR_MIN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_off, w_off_nxt;
   logic [STRIDE_W-1:0] r_stride, w_stride_nxt;
   logic [PW_W-1:0]     r_pw, w_pw_nxt;
   logic [NUM_W-1:0]    r_num, w_num_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_cfg_err, w_cfg_err_nxt;

   logic [7:0]          w_base0;
   logic [PW_W-1:0]     w_pw_adv;
   logic [PW_W-1:0]     w_pw_grow;
   logic                w_carry_top;
   logic                w_start_ok;
   logic                w_adv;
   logic [STRIDE_W-1:0] w_stride_in;

   assign w_base0     = CHAR_MIN + r_off;
   assign w_start_ok  = start && !abort && ({1'b0, start_offset} < 9'(RANGE));
   assign w_stride_in = (stride == '0) ? STRIDE_W'(1) : stride;

   // Odometer step: position 0 strides and reloads, upper positions wrap, carry ripples in one cycle.
   always_comb begin : advance
      logic       carry;
      logic [8:0] sum;
      w_pw_adv    = '0;
      w_carry_top = 1'b0;
      carry       = 1'b1;
      sum         = '0;
      for (int k = 0; k < int'(MAX_CHARS); k++) begin
         if (k < int'(r_num)) begin
            if (k == 0) begin
               sum = 9'(r_pw[7:0]) + 9'(r_stride);
               if (sum > {1'b0, CHAR_MAX}) begin
                  w_pw_adv[7:0] = w_base0;
                  carry         = 1'b1;
               end else begin
                  w_pw_adv[7:0] = sum[7:0];
                  carry         = 1'b0;
               end
            end else if (carry) begin
               if (r_pw[8*k +: 8] == CHAR_MAX) begin
                  w_pw_adv[8*k +: 8] = CHAR_MIN;
               end else begin
                  w_pw_adv[8*k +: 8] = r_pw[8*k +: 8] + 8'd1;
                  carry              = 1'b0;
               end
            end else begin
               w_pw_adv[8*k +: 8] = r_pw[8*k +: 8];
            end
            if (k == int'(r_num) - 1) w_carry_top = carry;
         end
      end
   end

   // First candidate of the next length: every live position back to its start value.
   always_comb begin
      w_pw_grow = '0;
      for (int k = 0; k < int'(MAX_CHARS); k++) begin
         if (k == 0)                  w_pw_grow[7:0]      = w_base0;
         else if (k <= int'(r_num))   w_pw_grow[8*k +: 8] = CHAR_MIN;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_off_nxt     = r_off;
      w_stride_nxt  = r_stride;
      w_pw_nxt      = r_pw;
      w_num_nxt     = r_num;
      w_valid_nxt   = r_valid;
      w_busy_nxt    = r_busy;
      w_done_nxt    = r_done;
      w_cfg_err_nxt = 1'b0;
      w_adv         = 1'b0;
      if (abort && r_state == S_RUN) begin
         w_state_nxt = S_IDLE;
         w_valid_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
      end else if (w_start_ok) begin
         w_state_nxt   = S_RUN;
         w_off_nxt     = start_offset;
         w_stride_nxt  = w_stride_in;
         w_pw_nxt      = '0;
         w_pw_nxt[7:0] = CHAR_MIN + start_offset;
         w_num_nxt     = NUM_W'(1);
         w_valid_nxt   = 1'b1;
         w_busy_nxt    = 1'b1;
         w_done_nxt    = 1'b0;
      end else begin
         if (start && !abort) w_cfg_err_nxt = 1'b1;
         if (r_state == S_RUN && r_valid && out_ready) begin
            w_adv = 1'b1;
            if (!w_carry_top) begin
               w_pw_nxt = w_pw_adv;
            end else if (r_num < NUM_W'(MAX_CHARS)) begin
               w_pw_nxt  = w_pw_grow;
               w_num_nxt = r_num + NUM_W'(1);
            end else begin
               w_state_nxt = S_DONE;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_off     <= '0;
         r_stride  <= '0;
         r_pw      <= '0;
         r_num     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_off     <= w_off_nxt;
         r_stride  <= w_stride_nxt;
         r_pw      <= w_pw_nxt;
         r_num     <= w_num_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_cfg_err <= w_cfg_err_nxt;
      end
   end

`ifdef BRUTE_FORCE_CAND_COUNT_EN
   logic [47:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    r_cnt <= '0;
      else if (w_start_ok)          r_cnt <= '0;
      else if (w_adv && r_cnt != '1) r_cnt <= r_cnt + 48'd1;
   end

   assign cand_count = r_cnt;
`endif

   assign out_valid = r_valid;
   assign password  = r_pw;
   assign num_chars = r_num;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_brute_force_gen.sv
// Self-checking bench for brute_force_gen (a..c, length up to 2) against an index-based keyspace model.
module tb_brute_force_gen;

   localparam int MAXC = 2;
   localparam int CMIN = 'h61;
   localparam int CMAX = 'h63;
   localparam int RNG  = CMAX - CMIN + 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  start_offset = '0;
   logic [2:0]  stride = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] password;
   logic [1:0]  num_chars;
   logic        busy, done, cfg_err;
`ifdef BRUTE_FORCE_CAND_COUNT_EN
   logic [47:0] cand_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] q_pw[$];
   int          q_n[$];

   brute_force_gen #(.MAX_CHARS(MAXC), .CHAR_MIN(8'h61), .CHAR_MAX(8'h63), .STRIDE_W(3)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .start_offset(start_offset), .stride(stride), .out_ready(out_ready),
      .out_valid(out_valid), .password(password), .num_chars(num_chars),
      .busy(busy), .done(done),
`ifdef BRUTE_FORCE_CAND_COUNT_EN
      .cfg_err(cfg_err), .cand_count(cand_count)
`else
      .cfg_err(cfg_err)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Keyspace as a mixed-radix index: position 0 has n0 stride values, upper positions have RNG values.
   function automatic void build_exp(input int off, input int strd);
      int s, n0, tot;
      s  = (strd == 0) ? 1 : strd;
      n0 = 0;
      for (int v = CMIN + off; v <= CMAX; v += s) n0++;
      q_pw.delete();
      q_n.delete();
      tot = n0;
      for (int len = 1; len <= MAXC; len++) begin
         for (int idx = 0; idx < tot; idx++) begin
            logic [15:0] w;
            int rest;
            w      = '0;
            rest   = idx / n0;
            w[7:0] = 8'(CMIN + off + s * (idx % n0));
            for (int k = 1; k < len; k++) begin
               w[8*k +: 8] = 8'(CMIN + rest % RNG);
               rest        = rest / RNG;
            end
            q_pw.push_back(w);
            q_n.push_back(len);
         end
         tot = tot * RNG;
      end
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int off, input int strd);
      start        = 1'b1;
      start_offset = 8'(off);
      stride       = 3'(strd);
      step();
      start        = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({out_valid, busy, done, cfg_err, num_chars, password} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h required 0", {out_valid, busy, done, cfg_err, num_chars, password});
      end
      step();
      reset = 1'b0;
      step();
      n_checks++;
      if ({out_valid, busy, done, cfg_err, num_chars, password} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h required 0", {out_valid, busy, done, cfg_err, num_chars, password});
      end
   endtask

   // mode 0: always ready; 1: ready dropped for 5 cycles after 4 handshakes; 2: random ready.
   task automatic test_sequence(input int off, input int strd, input int mode, input string nm);
      int hs, cyc, exp_tot, drop;
      logic rdy, held;
      logic [15:0] held_pw, last_pw;
      logic [1:0]  held_n;
      build_exp(off, strd);
      exp_tot = q_pw.size();
      last_pw = q_pw[exp_tot - 1];
      hs = 0; cyc = 0; drop = 0; held = 1'b0; held_pw = '0; held_n = '0;
      do_start(off, strd);
      while (!done && cyc < 1000) begin
         if (mode == 1) begin
            rdy = !(hs == 4 && drop < 5);
            if (!rdy) drop++;
         end else if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
         else rdy = 1'b1;
         out_ready = rdy;
         n_checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: valid %b busy %b required 1 1 at handshake %0d", nm, out_valid, busy, hs);
         end
         if (held) begin
            n_checks++;
            if (password !== held_pw || num_chars !== held_n) begin
               n_fail++;
               $display("FAIL %s_hold: got %h/%0d required %h/%0d", nm, password, num_chars, held_pw, held_n);
            end
         end
         held = 1'b0;
         if (out_valid && rdy) begin
            n_checks++;
            if (q_pw.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra: got %h beyond %0d candidates", nm, password, exp_tot);
            end else begin
               logic [15:0] ep;
               int en;
               ep = q_pw.pop_front();
               en = q_n.pop_front();
               if (password !== ep || int'(num_chars) !== en) begin
                  n_fail++;
                  $display("FAIL %s_cand%0d: got %h/%0d required %h/%0d", nm, hs, password, num_chars, ep, en);
               end
            end
            hs++;
         end else if (out_valid) begin
            held = 1'b1; held_pw = password; held_n = num_chars;
         end
         step();
         cyc++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (hs !== exp_tot || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done: handshakes %0d done %b valid %b busy %b required %0d 1 0 0",
                  nm, hs, done, out_valid, busy, exp_tot);
      end
      n_checks++;
      if (password !== last_pw) begin
         n_fail++;
         $display("FAIL %s_last: got %h required %h", nm, password, last_pw);
      end
`ifdef BRUTE_FORCE_CAND_COUNT_EN
      n_checks++;
      if (cand_count !== 48'(exp_tot)) begin
         n_fail++;
         $display("FAIL %s_count: got %0d required %0d", nm, cand_count, exp_tot);
      end
`endif
   endtask

   task automatic test_cfg_err();
      logic [15:0] pw;
      logic [1:0]  nc;
      do_start(0, 1);
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      step();
      pw = password; nc = num_chars;
      do_start(3, 1);
      n_checks++;
      if (cfg_err !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1 || password !== pw || num_chars !== nc) begin
         n_fail++;
         $display("FAIL cfg_err_pulse: err %b valid %b busy %b pw %h/%0d required 1 1 1 %h/%0d",
                  cfg_err, out_valid, busy, password, num_chars, pw, nc);
      end
      step();
      n_checks++;
      if (cfg_err !== 1'b0 || password !== pw) begin
         n_fail++;
         $display("FAIL cfg_err_clear: err %b pw %h required 0 %h", cfg_err, password, pw);
      end
   endtask

   task automatic test_abort();
      logic [15:0] pw;
      do_start(0, 1);
      out_ready = 1'b1;
      repeat (4) step();
      pw           = password;
      abort        = 1'b1;
      start        = 1'b1;
      start_offset = 8'd0;
      step();
      abort = 1'b0;
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || password !== pw) begin
         n_fail++;
         $display("FAIL abort_stop: valid %b busy %b done %b pw %h required 0 0 0 %h",
                  out_valid, busy, done, password, pw);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || password !== pw) begin
         n_fail++;
         $display("FAIL abort_idle: valid %b pw %h required 0 %h", out_valid, password, pw);
      end
      out_ready = 1'b0;
      do_start(0, 1);
      n_checks++;
      if (password !== 16'h0061 || num_chars !== 2'd1 || done !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_restart: pw %h n %0d done %b valid %b required 0061 1 0 1",
                  password, num_chars, done, out_valid);
      end
   endtask

   task automatic test_async_reset();
      do_start(1, 1);
      out_ready = 1'b1;
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, busy, done, cfg_err, num_chars, password} !== 22'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h required 0", {out_valid, busy, done, cfg_err, num_chars, password});
      end
`ifdef BRUTE_FORCE_CAND_COUNT_EN
      n_checks++;
      if (cand_count !== 48'd0) begin
         n_fail++;
         $display("FAIL async_reset_count: got %0d required 0", cand_count);
      end
`endif
      out_ready = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_sequence(0, 1, 0, "seq_o0_s1");
      test_sequence(1, 2, 0, "seq_o1_s2");
      test_sequence(0, 1, 1, "backpressure");
      for (int r = 0; r < 4; r++) begin
         test_sequence(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), 2, "random");
      end
      test_cfg_err();
      test_abort();
      test_async_reset();
      test_sequence(2, 0, 2, "after_reset");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
